// File: rtl/sdp_ram_clr_if.sv
// Port bundle for sdp_ram_clr: write port, read port and the busy/valid status.
// master drives requests; slave is the RAM.
interface sdp_ram_clr_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int BYTE_WIDTH = 4
);
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

  logic                  write_en;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [LANES-1:0]      wbe;
  logic [DATA_WIDTH-1:0] din;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  busy;

  modport master (
    output write_en, waddr, wbe, din, read_en, raddr,
    input  dout, dout_valid, busy
  );

  modport slave (
    input  write_en, waddr, wbe, din, read_en, raddr,
    output dout, dout_valid, busy
  );
endinterface

// File: rtl/sdp_ram_clr.sv
// Simple dual-port RAM with lane write enables, 1- or 2-cycle registered read,
// selectable read-during-write behaviour and a post-reset zero-fill sequencer.
module sdp_ram_clr #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 4,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic          clk,
  input logic          rst,
  sdp_ram_clr_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  busy_s;
  logic                  wr_go_s;
  logic                  rd_go_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [LANES-1:0]      wr_lane_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [LANES-1:0]      lane_en
  );
    logic [DATA_WIDTH-1:0] res;
    for (int l = 0; l < LANES; l++) begin
      if (lane_en[l]) begin
        res[l*BYTE_WIDTH +: BYTE_WIDTH] = new_word[l*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        res[l*BYTE_WIDTH +: BYTE_WIDTH] = old_word[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RESET != 0) begin
        state_q <= ST_CLEAR;
      end else begin
        state_q <= ST_READY;
      end
      clr_addr_q <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Clear owns the write port while busy; rst suppresses any array update or read issue.
  always_comb begin
    busy_s    = 1'b0;
    wr_go_s   = 1'b0;
    rd_go_s   = 1'b0;
    wr_addr_s = bus.waddr;
    wr_lane_s = bus.wbe;
    wr_data_s = bus.din;
    case (state_q)
      ST_CLEAR: begin
        busy_s    = 1'b1;
        wr_go_s   = !rst;
        wr_addr_s = clr_addr_q;
        wr_lane_s = {LANES{1'b1}};
        wr_data_s = {DATA_WIDTH{1'b0}};
      end
      ST_READY: begin
        wr_go_s = bus.write_en & !rst;
        rd_go_s = bus.read_en & !rst;
      end
      default: busy_s = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_go_s) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_lane_s[l]) begin
          mem_q[wr_addr_s][l*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_s[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Write-first mode bypasses the enabled lanes of a same-address write into the read.
  always_comb begin
    if ((RDW_MODE != 0) && wr_go_s && (wr_addr_s == bus.raddr)) begin
      rd_word_s = merge_lanes(mem_q[bus.raddr], wr_data_s, wr_lane_s);
    end else begin
      rd_word_s = mem_q[bus.raddr];
    end
  end

  always_comb begin
    s1_valid_d = rd_go_s;
    s2_valid_d = s1_valid_q;
    if (rd_go_s) begin
      s1_data_d = rd_word_s;
    end else begin
      s1_data_d = s1_data_q;
    end
    if (s1_valid_q) begin
      s2_data_d = s1_data_q;
    end else begin
      s2_data_d = s2_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data_q  <= {DATA_WIDTH{1'b0}};
      s2_data_q  <= {DATA_WIDTH{1'b0}};
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign bus.busy       = busy_s;
  assign bus.dout       = (READ_LATENCY == 2) ? s2_data_q : s1_data_q;
  assign bus.dout_valid = (READ_LATENCY == 2) ? s2_valid_q : s1_valid_q;

endmodule

// File: tb/tb_sdp_ram_clr.sv
// Bench for sdp_ram_clr: three configurations driven in lockstep, directed vectors
// plus a randomized run checked every cycle against an array-based reference model.
module tb_sdp_ram_clr;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [5:0]  wa;
  logic [1:0]  wbe;
  logic [7:0]  din;
  logic        re;
  logic [5:0]  ra;

  logic [2:0]       o_busy;
  logic [2:0]       o_val;
  logic [2:0][7:0]  o_dout;

  always #5 clk = ~clk;

  // Instance 0: latency 1, read-first, clear on reset.
  // Instance 1: latency 2, write-first, clear on reset.
  // Instance 2: latency 1, write-first, no clear.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdp_ram_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();
    assign bus.write_en = we;
    assign bus.waddr    = wa;
    assign bus.wbe      = wbe;
    assign bus.din      = din;
    assign bus.read_en  = re;
    assign bus.raddr    = ra;
    assign o_busy[g]    = bus.busy;
    assign o_val[g]     = bus.dout_valid;
    assign o_dout[g]    = bus.dout;
    sdp_ram_clr #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .BYTE_WIDTH    (BW),
      .READ_LATENCY  ((g == 1) ? 2 : 1),
      .RDW_MODE      ((g == 0) ? 0 : 1),
      .CLEAR_ON_RESET((g == 2) ? 0 : 1)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [7:0]  mm [3][DEPTH];
  int          clr_left [3];
  logic        slot_v [3][4];
  logic [7:0]  slot_d [3][4];
  logic        e_val  [3];
  logic [7:0]  e_dout [3];

  typedef struct {
    logic       we;
    logic [5:0] wa;
    logic [1:0] wbe;
    logic [7:0] din;
    logic       re;
    logic [5:0] ra;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
  } vec_t;
  vec_t tbl [14];

  function automatic int lat_of(int k);
    return (k == 1) ? 2 : 1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: results are scheduled for delivery lat cycles after issue; rst drops them.
  task automatic model_edge();
    logic [7:0] old;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        clr_left[k] = (k == 2) ? 0 : DEPTH;
        for (int s = 0; s < 4; s++) slot_v[k][s] = 1'b0;
        e_val[k]  = 1'b0;
        e_dout[k] = 8'h00;
      end else begin
        if (clr_left[k] > 0) begin
          mm[k][DEPTH - clr_left[k]] = 8'h00;
          clr_left[k]--;
        end else begin
          old = mm[k][ra];
          if (we) begin
            for (int l = 0; l < 2; l++) begin
              if (wbe[l]) mm[k][wa][l*BW +: BW] = din[l*BW +: BW];
            end
          end
          if (re) begin
            slot_v[k][(cyc + lat_of(k) - 1) % 4] = 1'b1;
            slot_d[k][(cyc + lat_of(k) - 1) % 4] = (k == 0) ? old : mm[k][ra];
          end
        end
        if (slot_v[k][cyc % 4]) begin
          e_val[k]  = 1'b1;
          e_dout[k] = slot_d[k][cyc % 4];
          slot_v[k][cyc % 4] = 1'b0;
        end else begin
          e_val[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy%0d", k), o_busy[k], (clr_left[k] > 0));
      check($sformatf("valid%0d", k), o_val[k], e_val[k]);
      check($sformatf("dout%0d", k), o_dout[k], e_dout[k]);
    end
  endtask

  task automatic idle();
    we = 1'b0; wa = 6'd0; wbe = 2'b00; din = 8'h00; re = 1'b0; ra = 6'd0;
  endtask

  int cnt;

  initial begin
    tbl[0]  = '{1'b1, 6'd5,  2'b11, 8'hA5, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 6'd5,  2'b01, 8'h3C, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 6'd0,  2'b00, 8'h00, 1'b1, 6'd5,  1'b1, 8'hAC, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 6'd7,  2'b11, 8'h11, 1'b0, 6'd0,  1'b0, 8'h00, 1'b1, 8'hAC};
    tbl[4]  = '{1'b1, 6'd7,  2'b11, 8'h22, 1'b1, 6'd7,  1'b1, 8'h11, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 6'd0,  2'b00, 8'h00, 1'b1, 6'd7,  1'b1, 8'h22, 1'b1, 8'h22};
    tbl[6]  = '{1'b1, 6'd9,  2'b10, 8'hF0, 1'b1, 6'd9,  1'b1, 8'h00, 1'b1, 8'h22};
    tbl[7]  = '{1'b0, 6'd0,  2'b00, 8'h00, 1'b1, 6'd9,  1'b1, 8'hF0, 1'b1, 8'hF0};
    tbl[8]  = '{1'b1, 6'd63, 2'b11, 8'h5A, 1'b1, 6'd62, 1'b1, 8'h00, 1'b1, 8'hF0};
    tbl[9]  = '{1'b0, 6'd0,  2'b00, 8'h00, 1'b1, 6'd63, 1'b1, 8'h5A, 1'b1, 8'h00};
    tbl[10] = '{1'b1, 6'd63, 2'b00, 8'hFF, 1'b1, 6'd63, 1'b1, 8'h5A, 1'b1, 8'h5A};
    tbl[11] = '{1'b0, 6'd0,  2'b00, 8'h00, 1'b1, 6'd63, 1'b1, 8'h5A, 1'b1, 8'h5A};
    tbl[12] = '{1'b0, 6'd0,  2'b00, 8'h00, 1'b0, 6'd0,  1'b0, 8'h00, 1'b1, 8'h5A};
    tbl[13] = '{1'b0, 6'd0,  2'b00, 8'h00, 1'b0, 6'd0,  1'b0, 8'h00, 1'b0, 8'h00};

    idle();
    rst = 1'b1;
    step();
    step();
    check("no_clear_busy", o_busy[2], 1'b0);

    // Clear window: writes/reads are live only in the no-clear instance, which gets initialised.
    rst = 1'b0;
    cnt = o_busy[0] ? 1 : 0;
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; wa = 6'(i); wbe = 2'b11; din = 8'($urandom_range(0, 255));
      re = (i > 0); ra = 6'(i - 1);
      step();
      if (o_busy[0]) cnt++;
    end
    check("busy_cycles", cnt, 64);
    check("busy_end", o_busy[0], 1'b0);

    idle(); re = 1'b1; ra = 6'd63;
    step();
    check("t1_valid", o_val[0], 1'b1);
    check("t1_dout", o_dout[0], 8'h00);
    idle();
    step();
    step();

    for (int i = 0; i < 14; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wbe = tbl[i].wbe; din = tbl[i].din;
      re = tbl[i].re; ra = tbl[i].ra;
      step();
      check($sformatf("tbl%0d_v0", i), o_val[0], tbl[i].v0);
      if (tbl[i].v0) check($sformatf("tbl%0d_d0", i), o_dout[0], tbl[i].d0);
      check($sformatf("tbl%0d_v1", i), o_val[1], tbl[i].v1);
      if (tbl[i].v1) check($sformatf("tbl%0d_d1", i), o_dout[1], tbl[i].d1);
    end

    // Latency-2 burst: four back-to-back reads of addresses holding 1..4.
    for (int i = 0; i < 4; i++) begin
      idle(); we = 1'b1; wa = 6'(i); wbe = 2'b11; din = 8'(i + 1);
      step();
    end
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i < 4) begin
        re = 1'b1; ra = 6'(i);
      end
      step();
      check($sformatf("t4_valid%0d", i), o_val[1], (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) check($sformatf("t4_dout%0d", i), o_dout[1], 8'(i));
    end

    // Reset restart in the middle of the clear; a write while busy must be dropped.
    idle(); we = 1'b1; wa = 6'd0; wbe = 2'b11; din = 8'hFF;
    step();
    idle(); rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = o_busy[0] ? 1 : 0;
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      if (i == 5) begin
        we = 1'b1; wa = 6'd0; wbe = 2'b11; din = 8'h55;
      end
      step();
      if (o_busy[0]) cnt++;
    end
    check("t5_busy_cycles", cnt, 64);
    check("t5_busy_end", o_busy[0], 1'b0);
    idle(); re = 1'b1; ra = 6'd0;
    step();
    check("t5_dout", o_dout[0], 8'h00);
    check("t5_dout_noclr", o_dout[2], 8'h55);

    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      we  = $urandom_range(0, 1) != 0;
      wa  = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
      wbe = 2'($urandom_range(0, 3));
      din = 8'($urandom_range(0, 255));
      re  = $urandom_range(0, 2) != 0;
      ra  = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
